// File: rtl/spi_poll_ctrl_if.sv
// spi_poll_ctrl_if -- bundle of the SPI poller's control and bus signals.
//   enable      : keep polling while high
//   miso        : shared slave data line
//   spi_clk     : serial clock, idles low
//   spi_cs      : per-slave active-low selects
//   frame_data  : last captured 75-bit frame, bit 0 received first
//   frame_slv   : slave index that sourced frame_data
//   frame_valid : one-cycle pulse marking new frame_data
//   frame_err   : trailer error, qualified by frame_valid
//   busy        : controller is not idle
// master = poll controller, slave = environment (slaves + consumer).
interface spi_poll_ctrl_if #(
    parameter int unsigned NUM_SLV = 4
) ();
    logic               enable;
    logic               miso;
    logic               spi_clk;
    logic [NUM_SLV-1:0] spi_cs;
    logic [74:0]        frame_data;
    logic [2:0]         frame_slv;
    logic               frame_valid;
    logic               frame_err;
    logic               busy;

    modport master (
        input  enable, miso,
        output spi_clk, spi_cs, frame_data, frame_slv, frame_valid, frame_err, busy
    );

    modport slave (
        output enable, miso,
        input  spi_clk, spi_cs, frame_data, frame_slv, frame_valid, frame_err, busy
    );
endinterface

// File: rtl/spi_poll_ctrl.sv
// spi_poll_ctrl -- round-robin poller of NUM_SLV interlock CPLD slaves over SPI.
// Each frame is 80 spi_clk periods; bits 0-74 are captured, bits 75-79 form a
// trailer that must read all zero. A GAP_CYC idle gap separates frames.
// Ports:
//   pclk_50M : system clock (sole clock)
//   rst_n    : synchronous active-low reset
//   bus      : spi_poll_ctrl_if master modport (enable, miso, spi_clk, spi_cs,
//              frame_data, frame_slv, frame_valid, frame_err, busy)
module spi_poll_ctrl #(
    parameter int unsigned NUM_SLV  = 4,
    parameter int unsigned HALF_DIV = 5,
    parameter int unsigned GAP_CYC  = 1000
) (
    input  logic          pclk_50M,
    input  logic          rst_n,
    spi_poll_ctrl_if.master bus
);

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_SETUP,
        ST_SHIFT,
        ST_HOLD,
        ST_GAP
    } state_t;

    localparam int unsigned   GAP_W    = (GAP_CYC > 1) ? $clog2(GAP_CYC) : 1;
    localparam logic [7:0]    DIV_LAST = 8'(HALF_DIV - 1);
    localparam logic [GAP_W-1:0] GAP_LAST = GAP_W'(GAP_CYC - 1);
    localparam logic [6:0]    BIT_LAST = 7'd79;
    localparam logic [6:0]    NUM_DATA = 7'd75;
    localparam logic [2:0]    SLV_LAST = 3'(NUM_SLV - 1);

    state_t             state_q, state_d;
    logic [7:0]         div_q, div_d;
    logic [6:0]         bit_q, bit_d;
    logic [GAP_W-1:0]   gap_q, gap_d;
    logic [2:0]         slv_q, slv_d;
    logic               sclk_q, sclk_d;
    logic [74:0]        shreg_q, shreg_d;
    logic               terr_q, terr_d;
    logic [74:0]        fdata_q, fdata_d;
    logic [2:0]         fslv_q, fslv_d;
    logic               ferr_q, ferr_d;
    logic               fvalid_q, fvalid_d;
    logic [NUM_SLV-1:0] cs_n;

    always_ff @(posedge pclk_50M) begin
        if (!rst_n) begin
            state_q  <= ST_IDLE;
            div_q    <= '0;
            bit_q    <= '0;
            gap_q    <= '0;
            slv_q    <= '0;
            sclk_q   <= 1'b0;
            shreg_q  <= '0;
            terr_q   <= 1'b0;
            fdata_q  <= '0;
            fslv_q   <= '0;
            ferr_q   <= 1'b0;
            fvalid_q <= 1'b0;
        end else begin
            state_q  <= state_d;
            div_q    <= div_d;
            bit_q    <= bit_d;
            gap_q    <= gap_d;
            slv_q    <= slv_d;
            sclk_q   <= sclk_d;
            shreg_q  <= shreg_d;
            terr_q   <= terr_d;
            fdata_q  <= fdata_d;
            fslv_q   <= fslv_d;
            ferr_q   <= ferr_d;
            fvalid_q <= fvalid_d;
        end
    end

    always_comb begin
        state_d  = state_q;
        div_d    = div_q;
        bit_d    = bit_q;
        gap_d    = gap_q;
        slv_d    = slv_q;
        sclk_d   = sclk_q;
        shreg_d  = shreg_q;
        terr_d   = terr_q;
        fdata_d  = fdata_q;
        fslv_d   = fslv_q;
        ferr_d   = ferr_q;
        fvalid_d = 1'b0;

        unique case (state_q)
            ST_IDLE: begin
                div_d  = '0;
                bit_d  = '0;
                sclk_d = 1'b0;
                if (bus.enable) begin
                    state_d = ST_SETUP;
                end
            end

            ST_SETUP: begin
                if (div_q == DIV_LAST) begin
                    div_d   = '0;
                    bit_d   = '0;
                    terr_d  = 1'b0;
                    state_d = ST_SHIFT;
                end else begin
                    div_d = div_q + 8'd1;
                end
            end

            ST_SHIFT: begin
                if (div_q == DIV_LAST) begin
                    div_d  = '0;
                    sclk_d = ~sclk_q;
                    // Sample on the cycle spi_clk drops: the slave launched the
                    // bit on the preceding rising edge, so it is mid-eye here.
                    if (sclk_q) begin
                        if (bit_q < NUM_DATA) begin
                            shreg_d = {bus.miso, shreg_q[74:1]};
                        end else begin
                            terr_d = terr_q | bus.miso;
                        end
                        bit_d = bit_q + 7'd1;
                        if (bit_q == BIT_LAST) begin
                            state_d = ST_HOLD;
                        end
                    end
                end else begin
                    div_d = div_q + 8'd1;
                end
            end

            ST_HOLD: begin
                if (div_q == DIV_LAST) begin
                    div_d    = '0;
                    gap_d    = '0;
                    fvalid_d = 1'b1;
                    fdata_d  = shreg_q;
                    fslv_d   = slv_q;
                    ferr_d   = terr_q;
                    slv_d    = (slv_q == SLV_LAST) ? 3'd0 : slv_q + 3'd1;
                    state_d  = ST_GAP;
                end else begin
                    div_d = div_q + 8'd1;
                end
            end

            ST_GAP: begin
                if (gap_q == GAP_LAST) begin
                    gap_d   = '0;
                    state_d = bus.enable ? ST_SETUP : ST_IDLE;
                end else begin
                    gap_d = gap_q + 1'b1;
                end
            end

            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // Only the current slave's select is driven low, and only while a frame
    // is in flight, so at most one select can ever be active.
    always_comb begin
        cs_n = '1;
        if (state_q == ST_SETUP || state_q == ST_SHIFT || state_q == ST_HOLD) begin
            for (int unsigned i = 0; i < NUM_SLV; i++) begin
                if (slv_q == 3'(i)) begin
                    cs_n[i] = 1'b0;
                end
            end
        end
    end

    assign bus.spi_clk     = sclk_q;
    assign bus.spi_cs      = cs_n;
    assign bus.frame_data  = fdata_q;
    assign bus.frame_slv   = fslv_q;
    assign bus.frame_valid = fvalid_q;
    assign bus.frame_err   = ferr_q;
    assign bus.busy        = (state_q != ST_IDLE);

endmodule

// File: tb/tb_spi_poll_ctrl.sv
// tb_spi_poll_ctrl -- directed bench for spi_poll_ctrl with HALF_DIV=2,
// GAP_CYC=20, NUM_SLV=4. Slave models drive an 80-bit pattern per slave and
// invert miso right after each falling spi_clk so only a sample taken on the
// high-to-low transition recovers the pattern.
module tb_spi_poll_ctrl;

    localparam int unsigned NUM_SLV  = 4;
    localparam int unsigned HALF_DIV = 2;
    localparam int unsigned GAP_CYC  = 20;

    logic pclk_50M = 1'b0;
    logic rst_n;

    spi_poll_ctrl_if #(.NUM_SLV(NUM_SLV)) bus ();

    spi_poll_ctrl #(
        .NUM_SLV (NUM_SLV),
        .HALF_DIV(HALF_DIV),
        .GAP_CYC (GAP_CYC)
    ) dut (
        .pclk_50M(pclk_50M),
        .rst_n   (rst_n),
        .bus     (bus)
    );

    always #10 pclk_50M = ~pclk_50M;

    int errors = 0;
    int checks = 0;

    task automatic chk(input string name, input logic [79:0] act, input logic [79:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // ---------------- slave model + bus monitor ----------------
    logic [79:0] pat [NUM_SLV];
    int          idx       = 0;
    logic        prev_clk  = 1'b0;
    logic [NUM_SLV-1:0] prev_cs = '1;
    int          rise_cnt  = 0;
    int          rise_at_fv = 0;
    int          fv_cnt    = 0;
    int          cs_falls  = 0;
    int          exp_slv   = 0;
    int          hi_run    = 0;
    bit          gap_valid = 1'b0;
    int          onehot_viol = 0;
    int          idle_tog  = 0;

    always @(negedge pclk_50M) begin
        int sel;
        sel = 0;
        for (int i = 0; i < NUM_SLV; i++) if (!bus.spi_cs[i]) sel = i;

        if (!rst_n || &bus.spi_cs) begin
            idx = 0;
            bus.miso = 1'b0;
        end else if (bus.spi_clk && !prev_clk) begin
            if (idx < 80) bus.miso = pat[sel][idx];
            idx++;
        end else if (!bus.spi_clk && prev_clk) begin
            bus.miso = ~bus.miso;
        end

        if (!$onehot0(~bus.spi_cs)) onehot_viol++;
        if (rst_n && (bus.spi_clk != prev_clk) && (&bus.spi_cs) && (&prev_cs)) idle_tog++;
        if (bus.spi_clk && !prev_clk) rise_cnt++;
        if (bus.frame_valid) begin
            fv_cnt++;
            rise_at_fv = rise_cnt;
        end

        if (!rst_n) begin
            exp_slv   = 0;
            gap_valid = 1'b0;
        end else begin
            if ((&prev_cs) && !(&bus.spi_cs)) begin
                cs_falls++;
                rise_cnt = 0;
                chk("cs_order", 80'(sel), 80'(exp_slv));
                if (gap_valid) chk("gap_len_ok", 80'(hi_run >= int'(GAP_CYC)), 80'(1));
                exp_slv = (sel + 1) % NUM_SLV;
            end
            if (!(&prev_cs) && (&bus.spi_cs)) gap_valid = 1'b1;
        end

        hi_run   = (&bus.spi_cs) ? hi_run + 1 : 0;
        prev_clk = bus.spi_clk;
        prev_cs  = bus.spi_cs;
    end

    // ---------------- helpers ----------------
    task automatic tick();
        @(negedge pclk_50M);
        #1;
    endtask

    task automatic wait_fv(input string name, output bit ok);
        ok = 1'b0;
        for (int n = 0; n < 1000; n++) begin
            tick();
            if (bus.frame_valid) begin
                ok = 1'b1;
                break;
            end
        end
        chk({name, "_fv_seen"}, 80'(ok), 80'(1));
    endtask

    task automatic wait_bit(input int b);
        bit hit;
        hit = 1'b0;
        for (int n = 0; n < 1000; n++) begin
            tick();
            if (!(&bus.spi_cs) && rise_cnt == b) begin
                hit = 1'b1;
                break;
            end
        end
        chk("reach_bit", 80'(hit), 80'(1));
    endtask

    typedef struct {
        logic [74:0] data;
        logic [4:0]  trail;
        logic [2:0]  exp_slv;
        logic [74:0] exp_data;
        logic        exp_err;
    } vec_t;

    vec_t vecs [5];

    initial begin
        bit          ok;
        int          fv_before;
        int          falls_before;
        logic [74:0] d;

        vecs[0] = '{75'h5_A5A5A5A5A5A5A5A5A5, 5'b00000, 3'd0, 75'h5_A5A5A5A5A5A5A5A5A5, 1'b0};
        vecs[1] = '{75'h1_23456789ABCDEF0123, 5'b00100, 3'd1, 75'h1_23456789ABCDEF0123, 1'b1};
        vecs[2] = '{75'h7_FFFFFFFFFFFFFFFFFF, 5'b10000, 3'd2, 75'h7_FFFFFFFFFFFFFFFFFF, 1'b1};
        vecs[3] = '{75'h0_000000000000000001, 5'b00001, 3'd3, 75'h0_000000000000000001, 1'b1};
        vecs[4] = '{75'h4_000000000000000000, 5'b00000, 3'd0, 75'h4_000000000000000000, 1'b0};
        for (int i = 0; i < NUM_SLV; i++) pat[i] = '0;

        // reset state
        rst_n = 1'b0;
        bus.enable = 1'b0;
        repeat (3) tick();
        chk("rst_spi_clk", 80'(bus.spi_clk), 80'(0));
        chk("rst_spi_cs", 80'(bus.spi_cs), 80'({NUM_SLV{1'b1}}));
        chk("rst_frame_valid", 80'(bus.frame_valid), 80'(0));
        chk("rst_frame_err", 80'(bus.frame_err), 80'(0));
        chk("rst_frame_data", 80'(bus.frame_data), 80'(0));
        chk("rst_frame_slv", 80'(bus.frame_slv), 80'(0));
        chk("rst_busy", 80'(bus.busy), 80'(0));
        rst_n = 1'b1;
        repeat (5) tick();
        chk("idle_busy", 80'(bus.busy), 80'(0));
        chk("idle_cs", 80'(bus.spi_cs), 80'({NUM_SLV{1'b1}}));

        // continuous polling, one table row per frame
        bus.enable = 1'b1;
        for (int v = 0; v < 5; v++) begin
            pat[vecs[v].exp_slv] = {vecs[v].trail, vecs[v].data};
            wait_fv("vec", ok);
            chk("vec_data", 80'(bus.frame_data), 80'(vecs[v].exp_data));
            chk("vec_slv", 80'(bus.frame_slv), 80'(vecs[v].exp_slv));
            chk("vec_err", 80'(bus.frame_err), 80'(vecs[v].exp_err));
            chk("vec_rises", 80'(rise_at_fv), 80'(80));
            chk("vec_busy_fv", 80'(bus.busy), 80'(1));
            repeat (10) tick();
            chk("vec_fv_pulse", 80'(bus.frame_valid), 80'(0));
            chk("vec_data_hold", 80'(bus.frame_data), 80'(vecs[v].exp_data));
            chk("vec_busy_gap", 80'(bus.busy), 80'(1));
            chk("vec_gap_cs", 80'(bus.spi_cs), 80'({NUM_SLV{1'b1}}));
        end

        // enable dropped mid-frame: frame completes, then idle for good
        d = 75'h2_AAAAAAAAAAAAAAAAAA;
        pat[1] = {5'b00000, d};
        wait_bit(40);
        bus.enable = 1'b0;
        wait_fv("drop", ok);
        chk("drop_data", 80'(bus.frame_data), 80'(d));
        chk("drop_slv", 80'(bus.frame_slv), 80'(1));
        chk("drop_err", 80'(bus.frame_err), 80'(0));
        chk("drop_rises", 80'(rise_at_fv), 80'(80));
        ok = 1'b0;
        for (int n = 0; n < 100; n++) begin
            tick();
            if (!bus.busy) begin
                ok = 1'b1;
                break;
            end
        end
        chk("drop_idle", 80'(ok), 80'(1));
        falls_before = cs_falls;
        repeat (200) tick();
        chk("drop_no_cs_activity", 80'(cs_falls), 80'(falls_before));
        chk("drop_cs_high", 80'(bus.spi_cs), 80'({NUM_SLV{1'b1}}));
        chk("drop_data_hold", 80'(bus.frame_data), 80'(d));

        // reset mid-frame on slave 2
        pat[2] = {5'b11111, 75'h3_0F0F0F0F0F0F0F0F0F};
        pat[0] = {5'b00000, 75'h6_123123123123123123};
        bus.enable = 1'b1;
        wait_bit(30);
        chk("rstmid_slv_sel", 80'(bus.spi_cs), 80'(4'b1011));
        fv_before = fv_cnt;
        rst_n = 1'b0;
        tick();
        chk("rstmid_cs", 80'(bus.spi_cs), 80'({NUM_SLV{1'b1}}));
        chk("rstmid_clk", 80'(bus.spi_clk), 80'(0));
        chk("rstmid_fv", 80'(bus.frame_valid), 80'(0));
        chk("rstmid_busy", 80'(bus.busy), 80'(0));
        repeat (3) tick();
        rst_n = 1'b1;
        tick();
        chk("rstmid_no_fv", 80'(fv_cnt), 80'(fv_before));
        chk("rstmid_data_clr", 80'(bus.frame_data), 80'(0));
        wait_fv("restart", ok);
        chk("restart_slv", 80'(bus.frame_slv), 80'(0));
        chk("restart_data", 80'(bus.frame_data), 80'(75'h6_123123123123123123));
        chk("restart_err", 80'(bus.frame_err), 80'(0));
        chk("restart_rises", 80'(rise_at_fv), 80'(80));
        bus.enable = 1'b0;
        repeat (60) tick();

        chk("onehot_cs", 80'(onehot_viol), 80'(0));
        chk("clk_idle_toggle", 80'(idle_tog), 80'(0));

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
